multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the RFplusALU datapath. Fetches a 16-bit instruction through a
//  req/ack memory port and sequences FETCH/DECODE/EXE/MEM/WB. Drives every RFplusALU control
//  input and the PC/IR/memory strobes. Holds the PSW (C,Z,N). Sits between the top level and RFplusALU.
// PARAMETERS
//  TIMEOUT  16  mem_ack wait limit in cycles (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock, rising edge
//  Reset      in   1   asynchronous, active-low reset
//  Start      in   1   leave IDLE, begin fetching
//  Ins        in   16  instruction word (valid with MemAck in FETCH)
//  MemAck     in   1   memory completes current MemReq
//  C,Z,N      in   1   ALU flags, valid in EXE
//  MemReq     out  1   memory request, held until MemAck
//  MemWe      out  1   write (STR only)
//  AddrSel    out  1   0=PC, 1=ALU Sum as memory address
//  IR_load    out  1   latch Ins into IR
//  PC_load    out  1   PC update strobe
//  PC_sel     out  1   0=PC+1, 1=PC+sext(Ins[7:0]) (branch)
//  WBRF,WBresource,RBresource,OprandB,LI,Buff_IDEXE,ALUop,PSW_C,Flag  out 1  RFplusALU controls
//  Halted     out  1   FSM in HALT
// BEHAVIOUR
//  Reset (async, Reset=0): state=IDLE, PSW={C,Z,N}=0, all outputs 0.
//  Decode on IR[15:11]: 00000 ALU (IR[1:0]: 00 ADD,01 ADC,10 SUB,11 SBC); 00001 LHI; 00010 LLI;
//   00011 LDR; 00100 STR; 00101 CMP (SUB, no WB); 11000 B; 11001 BEQ(Z=1); 11010 BNE(Z=0);
//   11111 HALT; any other opcode = NOP (DECODE->FETCH).
//  States / transitions (one state per cycle unless waiting):
//   IDLE:   Start=1 -> FETCH.
//   FETCH:  MemReq=1,AddrSel=0. Hold until MemAck; on ack cycle IR_load=1,PC_load=1,PC_sel=0 -> DECODE.
//   DECODE: Buff_IDEXE=1 (RF read latched). HALT->HALT, NOP->FETCH, else -> EXE.
//   EXE:    ALUop=0 add/1 sub; PSW_C=PSW.C for ADC/SBC, else 0. OprandB=0 (Rn) for ALU/CMP,
//           1 (imm) for LDR/STR. LI=1,RBresource=1 for LHI; LI=1,RBresource=0 for LLI.
//           ALU/CMP/LHI/LLI->WB; LDR/STR->MEM; branch: PC_load=PC_sel=1 iff taken -> FETCH.
//   MEM:    MemReq=1,AddrSel=1,MemWe=(STR). Hold until MemAck; LDR->WB, STR->FETCH.
//   WB:     WBRF=1 except CMP; WBresource=1 for LDR, 0 otherwise.
//           Flag=1 for ALU/CMP: PSW<= {C,Z,N} sampled this edge. -> FETCH.
//   HALT:   all strobes 0, Halted=1; exit only by Reset.
//  Rules:
//  - Outputs are Moore-decoded from state+IR except IR_load/PC_load in FETCH (gated by MemAck).
//  - MemReq held stable with constant address until ack; MemAck outside FETCH/MEM ignored.
//  - Ack in the first request cycle is legal: minimum fetch = 1 cycle.
//  - Latency (zero-wait memory): ALU 4 cycles, LDR 5, STR 4, branch 3, LHI/LLI 4, NOP 2.
//  - PSW changes only on Flag cycles; branches read the PSW, not live Z.
//  - Reset asserted mid-instruction aborts immediately; no partial WB or PSW update.
//  - Start ignored outside IDLE.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter (clog2(TIMEOUT+1) bits) clears on entry to FETCH/MEM and
//   counts wait cycles. TIMEOUT cycles without MemAck -> HALT, and sticky MemErr=1 (extra out
//   port, reset 0). Ack arriving in the same cycle as expiry wins.
//  Not defined: no counter, no MemErr port, FSM waits indefinitely.
// TESTING
//  1 Reset=0 mid-FETCH with MemReq=1 -> all outputs 0 same cycle; after release, Start -> FETCH.
//  2 ADD R1,R2,R3 (16'h0000|1<<8|2<<5|3<<2), zero-wait ack -> WBRF=1 in cycle 4, Flag=1,
//    ALUop=0, PSW_C=0; next FETCH on cycle 5.
//  3 SUB giving C=1, then ADC -> PSW_C=1 in ADC EXE; CMP -> WBRF=0, Flag=1.
//  4 LDR, MemAck delayed 3 cycles in MEM -> MemReq held 4 cycles, AddrSel=1, MemWe=0,
//    then WB with WBresource=1; STR -> MemWe=1, no WB.
//  5 BEQ with PSW.Z=1 -> PC_load=PC_sel=1 in EXE; Z=0 -> PC_load=0; HALT (16'hF800) -> Halted=1,
//    stays until Reset.
//  6 MEM_TIMEOUT_EN, TIMEOUT=16, MemAck never -> HALT with MemErr=1 after 16 wait cycles;
//    ack on cycle 16 -> normal progress.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multicycle control FSM for the RFplusALU datapath.
//
// Fetches a 16-bit instruction over a req/ack memory port, then sequences
// DECODE / EXE / MEM / WB. It drives every RFplusALU control input, the PC/IR
// load strobes and the memory strobes, and it holds the PSW flags (C,Z,N).
//
// Ports
//   clk                      system clock, rising edge
//   Reset                    asynchronous, active-low reset
//   Start                    leave IDLE and begin fetching (ignored elsewhere)
//   Ins[15:0]                instruction word, valid with MemAck in FETCH
//   MemAck                   memory completes the current MemReq
//   C, Z, N                  ALU flags
//   MemReq/MemWe/AddrSel     memory request, write strobe, address select (1 = ALU sum)
//   IR_load/PC_load/PC_sel   IR latch, PC update strobe, PC source (1 = branch target)
//   WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE, ALUop, PSW_C, Flag
//                            RFplusALU controls
//   Halted                   FSM is in HALT
//   MemErr                   sticky memory-timeout error (MEM_TIMEOUT_EN builds only)
//
// Build option: define MEM_TIMEOUT_EN to add a memory-ack watchdog. After
// TIMEOUT request cycles without MemAck the FSM enters HALT and sets MemErr.
// Without the macro the FSM waits for MemAck indefinitely.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] Ins,
   input  logic        MemAck,
   input  logic        C,
   input  logic        Z,
   input  logic        N,
   output logic        MemReq,
   output logic        MemWe,
   output logic        AddrSel,
   output logic        IR_load,
   output logic        PC_load,
   output logic        PC_sel,
   output logic        WBRF,
   output logic        WBresource,
   output logic        RBresource,
   output logic        OprandB,
   output logic        LI,
   output logic        Buff_IDEXE,
   output logic        ALUop,
   output logic        PSW_C,
   output logic        Flag,
`ifdef MEM_TIMEOUT_EN
   output logic        MemErr,
`endif
   output logic        Halted
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_HALT
   } state_t;

   // Opcode field IR[15:11]; these are fixed ISA encodings.
   localparam logic [4:0] OP_ALU = 5'b00000;
   localparam logic [4:0] OP_LHI = 5'b00001;
   localparam logic [4:0] OP_LLI = 5'b00010;
   localparam logic [4:0] OP_LDR = 5'b00011;
   localparam logic [4:0] OP_STR = 5'b00100;
   localparam logic [4:0] OP_CMP = 5'b00101;
   localparam logic [4:0] OP_B   = 5'b11000;
   localparam logic [4:0] OP_BEQ = 5'b11001;
   localparam logic [4:0] OP_BNE = 5'b11010;
   localparam logic [4:0] OP_HLT = 5'b11111;

   state_t      st, nxt;
   logic [15:0] ir;
   logic [2:0]  psw;          // {C,Z,N}
   logic        wait_expired; // watchdog ran out this cycle

   logic is_alu, is_lhi, is_lli, is_ldr, is_str, is_cmp;
   logic is_b, is_beq, is_bne, is_hlt, is_nop, br_taken;

   assign is_alu = (ir[15:11] == OP_ALU);
   assign is_lhi = (ir[15:11] == OP_LHI);
   assign is_lli = (ir[15:11] == OP_LLI);
   assign is_ldr = (ir[15:11] == OP_LDR);
   assign is_str = (ir[15:11] == OP_STR);
   assign is_cmp = (ir[15:11] == OP_CMP);
   assign is_b   = (ir[15:11] == OP_B);
   assign is_beq = (ir[15:11] == OP_BEQ);
   assign is_bne = (ir[15:11] == OP_BNE);
   assign is_hlt = (ir[15:11] == OP_HLT);
   assign is_nop = !(is_alu || is_lhi || is_lli || is_ldr || is_str || is_cmp ||
                     is_b || is_beq || is_bne || is_hlt);

   // Branches test the stored PSW.Z, never the live Z input.
   assign br_taken = is_b || (is_beq && psw[1]) || (is_bne && !psw[1]);

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;

   // Expiry is flagged on the TIMEOUT-th unacknowledged request cycle; an ack
   // in that same cycle still takes priority in the next-state logic.
   assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         wait_cnt <= '0;
         MemErr   <= 1'b0;
      end else begin
         // Counter is zero on every entry to FETCH/MEM because any cycle
         // outside an unacknowledged request clears it.
         if ((st == S_FETCH || st == S_MEM) && !MemAck) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_expired)
               MemErr <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end
`else
   assign wait_expired = 1'b0;

   // TIMEOUT only configures the watchdog; kept so overrides stay legal.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         st  <= S_IDLE;
         ir  <= '0;
         psw <= '0;
      end else begin
         st <= nxt;
         if (st == S_FETCH && MemAck)
            ir <= Ins;
         if (Flag)
            psw <= {C, Z, N};
      end
   end

   always_comb begin
      nxt        = st;
      MemReq     = 1'b0;
      MemWe      = 1'b0;
      AddrSel    = 1'b0;
      IR_load    = 1'b0;
      PC_load    = 1'b0;
      PC_sel     = 1'b0;
      WBRF       = 1'b0;
      WBresource = 1'b0;
      RBresource = 1'b0;
      OprandB    = 1'b0;
      LI         = 1'b0;
      Buff_IDEXE = 1'b0;
      ALUop      = 1'b0;
      PSW_C      = 1'b0;
      Flag       = 1'b0;
      Halted     = 1'b0;
      unique case (st)
         S_IDLE: begin
            if (Start)
               nxt = S_FETCH;
         end
         S_FETCH: begin
            MemReq = 1'b1;
            if (MemAck) begin
               IR_load = 1'b1;
               PC_load = 1'b1;
               nxt     = S_DECODE;
            end else if (wait_expired) begin
               nxt = S_HALT;
            end
         end
         S_DECODE: begin
            Buff_IDEXE = 1'b1;
            if (is_hlt)
               nxt = S_HALT;
            else if (is_nop)
               nxt = S_FETCH;
            else
               nxt = S_EXE;
         end
         S_EXE: begin
            ALUop      = (is_alu && ir[1]) || is_cmp;
            PSW_C      = is_alu && ir[0] && psw[2];
            OprandB    = is_ldr || is_str;
            LI         = is_lhi || is_lli;
            RBresource = is_lhi;
            PC_load    = br_taken;
            PC_sel     = br_taken;
            if (is_ldr || is_str)
               nxt = S_MEM;
            else if (is_b || is_beq || is_bne)
               nxt = S_FETCH;
            else
               nxt = S_WB;
         end
         S_MEM: begin
            MemReq  = 1'b1;
            AddrSel = 1'b1;
            MemWe   = is_str;
            if (MemAck)
               nxt = is_str ? S_FETCH : S_WB;
            else if (wait_expired)
               nxt = S_HALT;
         end
         S_WB: begin
            WBRF       = !is_cmp;
            WBresource = is_ldr;
            Flag       = is_alu || is_cmp;
            nxt        = S_FETCH;
         end
         S_HALT: begin
            Halted = 1'b1;
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule
